// File: rtl/draw_ball_pipe.sv
// draw_ball_pipe: pipelined VGA ball renderer, CNT circles, 3-cycle latency.
// Each pixel is tested against per-ball circles using ball state shadowed at
// frame_start; the lowest-index hit supplies the colour. Also flags frames in
// which any pixel fell inside two or more balls.
// Optional build macro: DRAW_BALL_OUTLINE_EN (draw 1-px rings instead of discs).
module draw_ball_pipe #(
    parameter int unsigned CNT = 3,
    parameter int unsigned CW  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic [10:0]       vcounter,
    input  logic [11:0]       hcounter,
    input  logic [CNT*CW-1:0] xs,
    input  logic [CNT*CW-1:0] ys,
    input  logic [CNT-1:0]    active,
    input  logic [5:0]        radius,
    input  logic [CNT*3-1:0]  colors,
    output logic [3:0]        out,
    output logic              overlap_frame
);

    // Signed delta width: wide enough for a 12-bit counter minus a CW-bit centre.
    localparam int unsigned W  = (CW > 12) ? CW + 1 : 13;
    localparam int unsigned DW = 2 * W + 1;

    // Shadowed ball state, only updated at frame_start
    logic [CNT*CW-1:0] sh_xs;
    logic [CNT*CW-1:0] sh_ys;
    logic [CNT-1:0]    sh_act;
    logic [5:0]        sh_rad;
    logic [CNT*3-1:0]  sh_col;

    // Stage 1 registers
    logic signed [W-1:0] s1_dx [CNT];
    logic signed [W-1:0] s1_dy [CNT];
    logic [11:0]         s1_sq;
    logic [CNT-1:0]      s1_act;
    logic [CNT*3-1:0]    s1_col;
    logic                s1_v;
`ifdef DRAW_BALL_OUTLINE_EN
    logic [11:0]         s1_inner;
    logic                s1_zero;
`endif

    // Stage 2 registers
    logic [CNT-1:0]      s2_hit;
    logic [CNT*3-1:0]    s2_col;
    logic                s2_v;

    // Combinational intermediates
    logic signed [W-1:0] dx_c [CNT];
    logic signed [W-1:0] dy_c [CNT];
    logic [11:0]         sq_c;
    logic [DW-1:0]       d_c [CNT];
    logic [CNT-1:0]      hit_c;
    logic [3:0]          out_c;
    logic [3:0]          nhit_c;
    logic                set_c;
    logic                sticky;
`ifdef DRAW_BALL_OUTLINE_EN
    logic [11:0]         inner_c;
`endif

    // Capture ball parameters at the start of vertical blanking
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_xs  <= '0;
            sh_ys  <= '0;
            sh_act <= '0;
            sh_rad <= '0;
            sh_col <= '0;
        end else if (frame_start) begin
            sh_xs  <= xs;
            sh_ys  <= ys;
            sh_act <= active;
            sh_rad <= radius;
            sh_col <= colors;
        end
    end

    // Stage 1 arithmetic: signed offsets from each centre, squared radius
    always_comb begin
        for (int unsigned i = 0; i < CNT; i++) begin
            dx_c[i] = $signed(W'(hcounter) - W'(sh_xs[i*CW +: CW]));
            dy_c[i] = $signed(W'(vcounter) - W'(sh_ys[i*CW +: CW]));
        end
    end

    assign sq_c = 12'(sh_rad) * 12'(sh_rad);
`ifdef DRAW_BALL_OUTLINE_EN
    assign inner_c = (12'(sh_rad) - 12'd1) * (12'(sh_rad) - 12'd1);
`endif

    // Stage 1 register: ball state travels with its pixel
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < CNT; i++) begin
                s1_dx[i] <= '0;
                s1_dy[i] <= '0;
            end
            s1_sq    <= '0;
            s1_act   <= '0;
            s1_col   <= '0;
            s1_v     <= 1'b0;
`ifdef DRAW_BALL_OUTLINE_EN
            s1_inner <= '0;
            s1_zero  <= 1'b0;
`endif
        end else begin
            for (int unsigned i = 0; i < CNT; i++) begin
                s1_dx[i] <= dx_c[i];
                s1_dy[i] <= dy_c[i];
            end
            s1_sq    <= sq_c;
            s1_act   <= sh_act;
            s1_col   <= sh_col;
            s1_v     <= 1'b1;
`ifdef DRAW_BALL_OUTLINE_EN
            s1_inner <= inner_c;
            s1_zero  <= (sh_rad == 6'd0);
`endif
        end
    end

    // Stage 2 arithmetic: squared distance and per-ball hit test
    always_comb begin
        for (int unsigned i = 0; i < CNT; i++) begin
            d_c[i] = $unsigned(DW'(s1_dx[i]) * DW'(s1_dx[i]) +
                               DW'(s1_dy[i]) * DW'(s1_dy[i]));
`ifdef DRAW_BALL_OUTLINE_EN
            hit_c[i] = s1_act[i] && (d_c[i] <= DW'(s1_sq)) &&
                       (s1_zero || (d_c[i] > DW'(s1_inner)));
`else
            hit_c[i] = s1_act[i] && (d_c[i] <= DW'(s1_sq));
`endif
        end
    end

    // Stage 2 register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_hit <= '0;
            s2_col <= '0;
            s2_v   <= 1'b0;
        end else begin
            s2_hit <= hit_c;
            s2_col <= s1_col;
            s2_v   <= s1_v;
        end
    end

    // Stage 3 logic: lowest-index priority select and multi-hit count
    always_comb begin
        out_c  = 4'b0000;
        nhit_c = 4'd0;
        for (int unsigned i = 0; i < CNT; i++) begin
            if (s2_hit[i] && !out_c[3]) begin
                out_c = {1'b1, s2_col[i*3 +: 3]};
            end
            nhit_c = nhit_c + 4'(s2_hit[i]);
        end
        set_c = s2_v && (nhit_c >= 4'd2);
    end

    // Output pixel register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out <= 4'b0000;
        end else begin
            out <= s2_v ? out_c : 4'b0000;
        end
    end

    // Per-frame overlap report; frame_start clears sticky ahead of a same-cycle set
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky        <= 1'b0;
            overlap_frame <= 1'b0;
        end else if (frame_start) begin
            overlap_frame <= sticky | set_c;
            sticky        <= 1'b0;
        end else if (set_c) begin
            sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_draw_ball_pipe.sv
// tb_draw_ball_pipe: directed table + randomized run against a geometric model.
module tb_draw_ball_pipe;

    localparam int CNT  = 3;
    localparam int CW   = 10;
    localparam int FARH = 2000;
    localparam int FARV = 1500;

    logic            clk;
    logic            rst_n;
    logic            frame_start;
    logic [10:0]     vcounter;
    logic [11:0]     hcounter;
    logic [CNT*CW-1:0] xs;
    logic [CNT*CW-1:0] ys;
    logic [CNT-1:0]  active;
    logic [5:0]      radius;
    logic [CNT*3-1:0] colors;
    logic [3:0]      out;
    logic            overlap_frame;

    draw_ball_pipe #(.CNT(CNT), .CW(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_start   (frame_start),
        .vcounter      (vcounter),
        .hcounter      (hcounter),
        .xs            (xs),
        .ys            (ys),
        .active        (active),
        .radius        (radius),
        .colors        (colors),
        .out           (out),
        .overlap_frame (overlap_frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Model state: ball geometry as latched at the last frame_start
    int         m_x [CNT];
    int         m_y [CNT];
    int         m_rad;
    logic [2:0] m_col [CNT];
    logic [CNT-1:0] m_act;
    bit         m_sticky;
    bit         m_ovl;
    logic [3:0] exp_q [$];
    bit         mul_q [$];

    function automatic void check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    endfunction

    // Geometric reference: first enabled ball whose circle contains the pixel
    function automatic void model(input int h, input int v, output logic [3:0] e, output bit mh);
        int n;
        int d;
        bit hit;
        n = 0;
        e = 4'b0000;
        for (int i = 0; i < CNT; i++) begin
            d   = (h - m_x[i]) * (h - m_x[i]) + (v - m_y[i]) * (v - m_y[i]);
            hit = m_act[i] && (d <= m_rad * m_rad);
`ifdef DRAW_BALL_OUTLINE_EN
            hit = hit && ((m_rad == 0) || (d > (m_rad - 1) * (m_rad - 1)));
`endif
            if (hit) begin
                n++;
                if (!e[3]) e = {1'b1, m_col[i]};
            end
        end
        mh = (n >= 2);
    endfunction

    // One pixel clock: drive, advance model across the edge, check at negedge
    task automatic tick(input bit fs, input int h, input int v);
        logic [3:0] e;
        logic [3:0] eo;
        bit mh;
        bit set_now;
        frame_start = fs;
        hcounter    = 12'(h);
        vcounter    = 11'(v);
        model(h, v, e, mh);
        exp_q.push_back(e);
        mul_q.push_back(mh);
        eo      = exp_q.pop_front();
        set_now = mul_q.pop_front();
        @(posedge clk);
        if (fs) begin
            m_ovl    = m_sticky | set_now;
            m_sticky = 1'b0;
            m_act    = active;
            m_rad    = int'(radius);
            for (int i = 0; i < CNT; i++) begin
                m_x[i]   = int'(xs[i*CW +: CW]);
                m_y[i]   = int'(ys[i*CW +: CW]);
                m_col[i] = colors[i*3 +: 3];
            end
        end else if (set_now) begin
            m_sticky = 1'b1;
        end
        @(negedge clk);
        check("out_model", out, eo);
        check("ovl_model", 4'(overlap_frame), 4'(m_ovl));
    endtask

    task automatic probe(input string name, input int h, input int v, input logic [3:0] exp);
        tick(1'b0, h, v);
        tick(1'b0, FARH, FARV);
        tick(1'b0, FARH, FARV);
        check(name, out, exp);
    endtask

    task automatic set_ball(input int i, input int x, input int y, input logic [2:0] c);
        xs[i*CW +: CW] = 10'(x);
        ys[i*CW +: CW] = 10'(y);
        colors[i*3 +: 3] = c;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        frame_start = 1'b1;
        active      = 3'b111;
        radius      = 6'd5;
        set_ball(0, 100, 50, 3'b100);
        set_ball(1, 300, 50, 3'b010);
        set_ball(2, 500, 50, 3'b001);
        hcounter    = 12'd100;
        vcounter    = 11'd50;
        repeat (2) @(posedge clk);
        @(negedge clk);
        m_act    = '0;
        m_sticky = 1'b0;
        m_ovl    = 1'b0;
        exp_q    = {};
        mul_q    = {};
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b0000);
        mul_q.push_back(1'b0);
        mul_q.push_back(1'b0);
        check("reset_out", out, 4'b0000);
        check("reset_ovl", 4'(overlap_frame), 4'b0000);
        rst_n       = 1'b1;
        frame_start = 1'b0;
    endtask

    task automatic apply_cfg(input int c);
        active = 3'b000;
        set_ball(0, 0, 0, 3'b000);
        set_ball(1, 0, 0, 3'b000);
        set_ball(2, 0, 0, 3'b000);
        case (c)
            1: begin radius = 6'd5; set_ball(0, 100, 50, 3'b100); active = 3'b001; end
            2: begin radius = 6'd4; set_ball(0, 100, 50, 3'b001); set_ball(1, 102, 50, 3'b010); active = 3'b011; end
            3: begin radius = 6'd3; set_ball(0, 0, 0, 3'b011); active = 3'b001; end
            4: begin radius = 6'd0; set_ball(0, 10, 10, 3'b111); active = 3'b001; end
            default: begin radius = 6'd5; set_ball(0, 10, 10, 3'b111); set_ball(1, 500, 500, 3'b010); active = 3'b010; end
        endcase
        tick(1'b1, FARH, FARV);
        repeat (3) tick(1'b0, FARH, FARV);
    endtask

    function automatic int clampi(input int x, input int lo, input int hi);
        return (x < lo) ? lo : ((x > hi) ? hi : x);
    endfunction

    task automatic rand_balls();
        int x0;
        int y0;
        x0     = int'($urandom_range(0, 1023));
        y0     = int'($urandom_range(0, 1023));
        radius = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 12));
        active = 3'($urandom_range(0, 7));
        for (int i = 0; i < CNT; i++) begin
            set_ball(i, clampi(x0 + int'($urandom_range(0, 40)) - 20, 0, 1023),
                        clampi(y0 + int'($urandom_range(0, 40)) - 20, 0, 1023),
                        3'($urandom_range(0, 7)));
        end
    endtask

    typedef struct {
        int         cfg;
        int         h;
        int         v;
        logic [3:0] exp;
        string      name;
    } probe_t;

    probe_t tbl [$];

    function automatic probe_t mk(input int c, input int h, input int v, input logic [3:0] e, input string n);
        probe_t p;
        p.cfg = c; p.h = h; p.v = v; p.exp = e; p.name = n;
        return p;
    endfunction

    initial begin
        int cur_cfg;
        int b;
        int r;

        // Directed probe table
`ifdef DRAW_BALL_OUTLINE_EN
        tbl.push_back(mk(1, 100, 50, 4'b0000, "centre_ring"));
        tbl.push_back(mk(2, 101, 50, 4'b0000, "prio_inner"));
        tbl.push_back(mk(3,   0,  0, 4'b0000, "origin_ring"));
        tbl.push_back(mk(5, 500, 500, 4'b0000, "b1_centre_ring"));
`else
        tbl.push_back(mk(1, 100, 50, 4'b1100, "centre_hit"));
        tbl.push_back(mk(2, 101, 50, 4'b1001, "prio_low_wins"));
        tbl.push_back(mk(3,   0,  0, 4'b1011, "origin_hit"));
        tbl.push_back(mk(5, 500, 500, 4'b1010, "b1_centre"));
`endif
        tbl.push_back(mk(1, 106, 50, 4'b0000, "outside_r"));
        tbl.push_back(mk(1, 103, 54, 4'b1100, "on_circle"));
        tbl.push_back(mk(1, 105, 50, 4'b1100, "rim_x"));
        tbl.push_back(mk(2, 101, 53, 4'b1001, "prio_both"));
        tbl.push_back(mk(2, 104, 50, 4'b1001, "prio_b0_rim"));
        tbl.push_back(mk(2, 106, 50, 4'b1010, "b1_only"));
        tbl.push_back(mk(3,   3,  0, 4'b1011, "origin_rim"));
        tbl.push_back(mk(3,   0,  4, 4'b0000, "origin_out"));
        tbl.push_back(mk(3,   2,  2, 4'b1011, "origin_diag"));
        tbl.push_back(mk(4,  10, 10, 4'b1111, "r0_centre"));
        tbl.push_back(mk(4,  11, 10, 4'b0000, "r0_right"));
        tbl.push_back(mk(4,  10,  9, 4'b0000, "r0_up"));
        tbl.push_back(mk(5,  10, 10, 4'b0000, "inactive_b0"));
        tbl.push_back(mk(5, 505, 500, 4'b1010, "b1_rim"));

        xs = '0; ys = '0; colors = '0; active = '0; radius = '0;
        frame_start = 1'b0; hcounter = '0; vcounter = '0;
        do_reset();

        // frame_start seen only during reset: shadow stays inactive
        probe("post_reset_nohit", 100, 50, 4'b0000);

        cur_cfg = 0;
        foreach (tbl[k]) begin
            if (tbl[k].cfg != cur_cfg) begin
                apply_cfg(tbl[k].cfg);
                cur_cfg = tbl[k].cfg;
            end
            probe(tbl[k].name, tbl[k].h, tbl[k].v, tbl[k].exp);
        end

        // Overlap: set in the same cycle as frame_start, then clear priority
        apply_cfg(2);
        tick(1'b0, 101, 53);
        tick(1'b0, FARH, FARV);
        tick(1'b1, FARH, FARV);
        check("ovl_same_cycle", 4'(overlap_frame), 4'b0001);
        repeat (3) tick(1'b0, FARH, FARV);
        tick(1'b1, FARH, FARV);
        check("ovl_clear_prio", 4'(overlap_frame), 4'b0000);

        // Overlap across frames, then a frame with separated balls
        probe("ovl_pixel", 101, 53, 4'b1001);
        set_ball(1, 300, 50, 3'b010);
        tick(1'b1, FARH, FARV);
        check("ovl_frame_set", 4'(overlap_frame), 4'b0001);
        repeat (3) tick(1'b0, FARH, FARV);
        probe("sep_pixel", 101, 53, 4'b1001);
        tick(1'b1, FARH, FARV);
        check("ovl_frame_clear", 4'(overlap_frame), 4'b0000);

        // Shadowing: mid-frame move is invisible until frame_start
        apply_cfg(1);
        set_ball(0, 200, 50, 3'b100);
        probe("shadow_old_hit", 105, 50, 4'b1100);
        probe("shadow_new_miss", 205, 50, 4'b0000);
        tick(1'b1, FARH, FARV);
        repeat (3) tick(1'b0, FARH, FARV);
        probe("shadow_new_hit", 205, 50, 4'b1100);
        probe("shadow_old_miss", 105, 50, 4'b0000);

        // Mid-stream reset aborts in-flight pixels
        tick(1'b0, 205, 50);
        tick(1'b0, 205, 50);
        do_reset();
        repeat (4) tick(1'b0, 100, 50);

        // Randomized frames against the model
        for (int f = 0; f < 8; f++) begin
            rand_balls();
            tick(1'b1, FARH, FARV);
            for (int p = 0; p < 200; p++) begin
                if ($urandom_range(0, 9) == 0) rand_balls();
                b = int'($urandom_range(0, CNT - 1));
                r = int'(radius) + 2;
                tick(($urandom_range(0, 49) == 0),
                     clampi(int'(xs[b*CW +: CW]) + int'($urandom_range(0, 2 * r)) - r, 0, 4095),
                     clampi(int'(ys[b*CW +: CW]) + int'($urandom_range(0, 2 * r)) - r, 0, 2047));
            end
        end
        tick(1'b1, FARH, FARV);
        repeat (3) tick(1'b0, FARH, FARV);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
